// File: rtl/ldst_mem_responder_if.sv
// rtl/ldst_mem_responder_if.sv - load/store port bundle between CPU and data memory
//
// Purpose: groups the CPU load/store handshake into one interface.
// Signals:
//   addr        byte address (word index = addr[IW-1:2])
//   rd, wr      read / write request
//   wrdata      write data, lanes used in place
//   byte_en     lane enables, bit k selects bits [8k+7:8k]
//   rddata      read data, disabled lanes read as 0
//   waitrequest responder not ready (registered)
// Modports: master (CPU side), slave (memory side).
interface ldst_mem_responder_if #(
  parameter int IW = 32
);
  logic [IW-1:0]   addr;
  logic            rd;
  logic            wr;
  logic [IW-1:0]   wrdata;
  logic [IW/8-1:0] byte_en;
  logic [IW-1:0]   rddata;
  logic            waitrequest;

  modport master (
    output addr, rd, wr, wrdata, byte_en,
    input  rddata, waitrequest
  );

  modport slave (
    input  addr, rd, wr, wrdata, byte_en,
    output rddata, waitrequest
  );
endinterface

// File: rtl/ldst_mem_responder.sv
// rtl/ldst_mem_responder.sv - word-organised data memory answering the CPU load/store port
//
// Purpose: paced responder with a registered waitrequest, byte-enabled writes and
// combinational read data in the accept cycle.
// Optional feature macro: LDST_MEM_STAT_EN builds saturating accepted-read/write counters;
// without it the counter ports are tied to 0.
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       synchronous active-high reset
//   ldst        load/store bus (slave modport of ldst_mem_responder_if)
//   o_err       sticky protocol/range error flag
//   o_rd_count  accepted-read counter (16 bit, saturating)
//   o_wr_count  accepted-write counter (16 bit, saturating)
module ldst_mem_responder #(
  parameter int IW          = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  ldst_mem_responder_if.slave        ldst,
  output logic                       o_err,
  output logic [15:0]                o_rd_count,
  output logic [15:0]                o_wr_count
);

  localparam int NL = IW / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
  localparam logic [IW-1:0] DEPTH_W  = IW'(DEPTH);
  localparam bit            STALL    = (WAIT_CYCLES > 0);

  typedef enum logic {
    S_WAIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          waitreq_q;
  logic          err_q;

  logic [IW-1:0] mem [DEPTH];

  logic [IW-3:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          accept;
  logic          both;
  logic          do_write;
  logic          do_read;
  logic [IW-1:0] lane_mask;
  logic [IW-1:0] rd_word;
  logic          unused_addr_bits;

  // The low address bits never select anything: lanes are used in place.
  assign unused_addr_bits = &{1'b0, ldst.addr[1:0]};

  assign word_idx = ldst.addr[IW-1:2];
  assign in_range = {2'b00, word_idx} < DEPTH_W;
  assign mem_idx  = word_idx[AW-1:0];

  // Accepting is purely a function of the registered READY state, so
  // waitrequest never depends combinationally on the request inputs.
  assign accept   = (state == S_READY) && (ldst.rd || ldst.wr);
  assign both     = ldst.rd && ldst.wr;
  // A write on the reset edge is discarded.
  assign do_write = accept && ldst.wr && in_range && !reset;
  // rd+wr collisions perform the write but return no data.
  assign do_read  = accept && ldst.rd && !ldst.wr && in_range;

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NL; k++) begin
      lane_mask[8*k +: 8] = {8{ldst.byte_en[k]}};
    end
  end

  assign rd_word          = mem[mem_idx];
  assign ldst.rddata      = do_read ? (rd_word & lane_mask) : '0;
  assign ldst.waitrequest = waitreq_q;
  assign o_err            = err_q;

  // Memory array: no reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < NL; k++) begin
        if (ldst.byte_en[k]) begin
          mem[mem_idx][8*k +: 8] <= ldst.wrdata[8*k +: 8];
        end
      end
    end
  end

  // Pacing FSM; waitreq_q is loaded with the value matching the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STALL ? S_WAIT : S_READY;
      cnt       <= CNT_LOAD;
      waitreq_q <= STALL;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            state     <= S_READY;
            waitreq_q <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_READY: begin
          if (accept) begin
            if (!in_range || both) begin
              err_q <= 1'b1;
            end
            if (STALL) begin
              state     <= S_WAIT;
              cnt       <= CNT_LOAD;
              waitreq_q <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_WAIT;
          cnt       <= CNT_LOAD;
          waitreq_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef LDST_MEM_STAT_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  // A collision counts as a write only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (accept) begin
      if (ldst.wr) begin
        if (wr_count_q != 16'hFFFF) begin
          wr_count_q <= wr_count_q + 16'd1;
        end
      end else if (rd_count_q != 16'hFFFF) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign o_rd_count = rd_count_q;
  assign o_wr_count = wr_count_q;
`else
  assign o_rd_count = '0;
  assign o_wr_count = '0;
`endif

endmodule

// File: tb/tb_ldst_mem_responder.sv
// tb/tb_ldst_mem_responder.sv - directed self-checking bench for ldst_mem_responder
module tb_ldst_mem_responder;

`ifdef LDST_MEM_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        err;
  logic [15:0] rdc;
  logic [15:0] wrc;
  logic        err0;
  logic [15:0] rdc0;
  logic [15:0] wrc0;

  int n_cmp;
  int n_fail;

  ldst_mem_responder_if #(.IW(32)) bus ();
  ldst_mem_responder_if #(.IW(32)) bus0 ();

  ldst_mem_responder #(.IW(32), .DEPTH(1024), .WAIT_CYCLES(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .ldst       (bus.slave),
    .o_err      (err),
    .o_rd_count (rdc),
    .o_wr_count (wrc)
  );

  ldst_mem_responder #(.IW(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .ldst       (bus0.slave),
    .o_err      (err0),
    .o_rd_count (rdc0),
    .o_wr_count (wrc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.addr = '0;  bus.rd = 1'b0;  bus.wr = 1'b0;  bus.wrdata = '0;  bus.byte_en = '0;
    bus0.addr = '0; bus0.rd = 1'b0; bus0.wr = 1'b0; bus0.wrdata = '0; bus0.byte_en = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One access on dut (z=0) or dut0 (z=1). Called at posedge+1, returns at
  // posedge+1 after the accept edge. stalls = cycles waited for waitrequest=0.
  task automatic acc(input bit z, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rdv, output int stalls);
    stalls = 0;
    while ((z ? bus0.waitrequest : bus.waitrequest) !== 1'b0 && stalls < 20) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (stalls >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL acc_timeout: waitrequest still %b, required 0 within 20 cycles",
               z ? bus0.waitrequest : bus.waitrequest);
    end
    if (z) begin
      bus0.addr = a; bus0.rd = rd; bus0.wr = wr; bus0.wrdata = wd; bus0.byte_en = be;
    end else begin
      bus.addr = a; bus.rd = rd; bus.wr = wr; bus.wrdata = wd; bus.byte_en = be;
    end
    #3;
    rdv = z ? bus0.rddata : bus.rddata;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    logic w[4];
    idle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = bus.waitrequest;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++; if (w[0] !== 1'b1) begin n_fail++; $display("FAIL reset_wait0: got %b want 1", w[0]); end
    n_cmp++; if (w[1] !== 1'b1) begin n_fail++; $display("FAIL reset_wait1: got %b want 1", w[1]); end
    n_cmp++; if (w[2] !== 1'b0) begin n_fail++; $display("FAIL reset_wait2: got %b want 0", w[2]); end
    n_cmp++; if (w[3] !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 0", w[3]); end
    n_cmp++; if (bus.rddata !== 32'h0) begin n_fail++; $display("FAIL reset_rddata: got %h want 0", bus.rddata); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (rdc !== 16'd0 || wrc !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", rdc, wrc); end
    n_cmp++; if (bus0.waitrequest !== 1'b0) begin n_fail++; $display("FAIL reset_wait_w0: got %b want 0", bus0.waitrequest); end
  endtask

  task automatic test_word();
    logic [31:0] r;
    int s;
    acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, s);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL word_wr_rddata: got %h want 0", r); end
    n_cmp++; if (s !== 0) begin n_fail++; $display("FAIL word_wr_stalls: got %0d want 0", s); end
    acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, r, s);
    n_cmp++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd: got %h want deadbeef", r); end
    n_cmp++; if (s !== 2) begin n_fail++; $display("FAIL word_rd_stalls: got %0d want 2", s); end
  endtask

  task automatic test_byte();
    logic [31:0] r;
    int s;
    acc(0, 1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, r, s);
    acc(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'b1111, r, s);
    n_cmp++; if (r !== 32'hDEADBEAA) begin n_fail++; $display("FAIL byte_merge: got %h want deadbeaa", r); end
    acc(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0011, r, s);
    n_cmp++; if (r !== 32'h0000BEAA) begin n_fail++; $display("FAIL byte_mask: got %h want 0000beaa", r); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL byte_err: got %b want 0", err); end
  endtask

  task automatic test_range();
    logic [31:0] r;
    int s;
    acc(0, 1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF, r, s);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL range_err_pre: got %b want 0", err); end
    acc(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, r, s);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL range_rd: got %h want 0", r); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err: got %b want 1", err); end
    acc(0, 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, r, s);
    acc(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, r, s);
    n_cmp++; if (r !== 32'h11223344) begin n_fail++; $display("FAIL range_wr_dropped: got %h want 11223344", r); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_rdwr();
    logic [31:0] r;
    int s;
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rdwr_err_cleared: got %b want 0", err); end
    acc(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, r, s);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL rdwr_rddata: got %h want 0", r); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rdwr_err: got %b want 1", err); end
    acc(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, r, s);
    n_cmp++; if (r !== 32'h12345678) begin n_fail++; $display("FAIL rdwr_written: got %h want 12345678", r); end
    n_cmp++;
    if (rdc !== (STAT ? 16'd1 : 16'd0) || wrc !== (STAT ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL rdwr_counts: got %0d/%0d want %0d/%0d", rdc, wrc, STAT ? 1 : 0, STAT ? 1 : 0);
    end
  endtask

  task automatic test_stats();
    logic [31:0] r;
    int s;
    do_reset();
    acc(0, 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, r, s);
    acc(0, 1'b0, 1'b1, 32'h34, 32'h5A5A5A5A, 4'hF, r, s);
    acc(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, r, s);
    n_cmp++; if (r !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL stats_rd30: got %h want a5a5a5a5", r); end
    acc(0, 1'b1, 1'b0, 32'h34, 32'h0, 4'hF, r, s);
    n_cmp++; if (r !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL stats_rd34: got %h want 5a5a5a5a", r); end
    acc(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, r, s);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL stats_be0: got %h want 0", r); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL stats_be0_err: got %b want 0", err); end
    n_cmp++;
    if (rdc !== (STAT ? 16'd3 : 16'd0) || wrc !== (STAT ? 16'd2 : 16'd0)) begin
      n_fail++; $display("FAIL stats_counts: got %0d/%0d want %0d/%0d", rdc, wrc, STAT ? 3 : 0, STAT ? 2 : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r[5];
    int s[5];
    acc(1, 1'b0, 1'b1, 32'h40, 32'h01020304, 4'hF, r[0], s[0]);
    acc(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, r[1], s[1]);
    acc(1, 1'b0, 1'b1, 32'h44, 32'hFFEEDDCC, 4'b1100, r[2], s[2]);
    acc(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'b1100, r[3], s[3]);
    acc(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'b0001, r[4], s[4]);
    n_cmp++; if (r[1] !== 32'h01020304) begin n_fail++; $display("FAIL b2b_rd_after_wr: got %h want 01020304", r[1]); end
    n_cmp++; if (r[3] !== 32'hFFEE0000) begin n_fail++; $display("FAIL b2b_upper: got %h want ffee0000", r[3]); end
    n_cmp++; if (r[4] !== 32'h00000004) begin n_fail++; $display("FAIL b2b_lane0: got %h want 00000004", r[4]); end
    n_cmp++;
    if ((s[0] | s[1] | s[2] | s[3] | s[4]) != 0) begin
      n_fail++; $display("FAIL b2b_stalls: got %0d %0d %0d %0d %0d want all 0", s[0], s[1], s[2], s[3], s[4]);
    end
    n_cmp++; if (bus0.waitrequest !== 1'b0) begin n_fail++; $display("FAIL b2b_wait: got %b want 0", bus0.waitrequest); end
    n_cmp++;
    if (rdc0 !== (STAT ? 16'd3 : 16'd0) || wrc0 !== (STAT ? 16'd2 : 16'd0)) begin
      n_fail++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", rdc0, wrc0, STAT ? 3 : 0, STAT ? 2 : 0);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] r;
    int s;
    int n;
    acc(0, 1'b0, 1'b1, 32'h50, 32'h0BADC0DE, 4'hF, r, s);
    n = 0;
    while (bus.waitrequest !== 1'b0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL rst_mid_ready: got %0d stall cycles want 2", n); end
    bus.addr = 32'h50; bus.wr = 1'b1; bus.wrdata = 32'hFFFFFFFF; bus.byte_en = 4'hF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    n_cmp++; if (bus.waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_mid_wait: got %b want 1", bus.waitrequest); end
    n_cmp++; if (rdc !== 16'd0 || wrc !== 16'd0) begin n_fail++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", rdc, wrc); end
    acc(0, 1'b1, 1'b0, 32'h50, 32'h0, 4'hF, r, s);
    n_cmp++; if (r !== 32'h0BADC0DE) begin n_fail++; $display("FAIL rst_mid_mem: got %h want 0badc0de", r); end
    n_cmp++; if (s !== 2) begin n_fail++; $display("FAIL rst_mid_stalls: got %0d want 2", s); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_word();
    test_byte();
    test_range();
    test_rdwr();
    test_stats();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
